audio_sample_sequencer: RTL
===========================

Name: audio_sample_sequencer

Overview:
Sequences one audio sample at a time between the audio codec handshake (read_ready/read, write_ready/write) and a multi-cycle processing engine, such as averaging_filter or a future FIR engine, attached through a start/done handshake. It sits between the codec and the processing block in the top level, replacing the ad-hoc read = write = read_ready & write_ready gluing. It provides per-sample mode selection (pass, process, mute), a processing timeout with raw-sample fallback, and saturating diagnostic counters. Output is mono: the same value is driven on both channels.

Parameters:
W, 24, sample width in bits (matches codec readdata/writedata).
TIMEOUT, 64, max cycles in PROCESS before fallback; must be >= 2.
CNT_W, 16, width of diagnostic counters.

Ports:
clk  in  1  system clock (CLOCK_50 domain)
reset  in  1  synchronous, active-high reset
mode  in  2  00 pass, 01 process, 10 mute, 11 process
read_ready  in  1  codec has an ADC sample available
write_ready  in  1  codec can accept a DAC sample
readdata_left  in  W  codec left-channel ADC sample
read  out  1  pop one sample from the codec
write  out  1  push one sample to the codec
writedata_left  out  W  DAC sample, left channel
writedata_right  out  W  DAC sample, right channel (always equals left)
proc_start  out  1  one-cycle pulse: proc_data_in is valid
proc_data_in  out  W  sample handed to the engine
proc_done  in  1  engine result is valid this cycle
proc_data_out  in  W  engine result
busy  out  1  high whenever state != IDLE
timeout_count  out  CNT_W  number of engine timeouts, saturating
stall_count  out  CNT_W  cycles spent in EMIT with write_ready=0, saturating

Behaviour:
- Reset (synchronous, active-high, one cycle is sufficient):
  - State goes to IDLE.
  - writedata_*, proc_data_in, both counters and the sample/result registers are cleared to 0.
  - read, write and proc_start are 0 during any reset cycle.
  - Reset mid-operation discards the in-flight sample. No write is issued for it.
- FSM has four states: IDLE, PROCESS, EMIT, plus a one-cycle START substate inside PROCESS (implementation choice, same external timing).
- IDLE:
  - read = read_ready (combinational, state-qualified).
  - On read=1: sample_q <= readdata_left and mode_q <= mode, both in the same cycle.
  - Next state: PROCESS if mode is 01 or 11; otherwise EMIT.
  - When going to EMIT, writedata <= sample_q source (pass) or 0 (mute), registered on the capture edge.
- PROCESS:
  - proc_start=1 in the first PROCESS cycle only.
  - proc_data_in holds sample_q for the whole state.
  - proc_done is honoured only from the cycle after proc_start.
  - On proc_done: writedata <= proc_data_out, then go to EMIT.
  - The timer counts PROCESS cycles. When it reaches TIMEOUT without done: writedata <= sample_q (raw fallback), timeout_count += 1, go to EMIT.
  - If proc_done and timeout occur in the same cycle, done wins and the counter does not increment.
- EMIT:
  - write = write_ready (combinational, state-qualified).
  - read is held at 0.
  - On write=1, go to IDLE.
  - Each EMIT cycle with write_ready=0 increments stall_count.
- Latency, pass/mute: read at cycle t, write no earlier than t+1. Throughput is one sample per 2 cycles max.
- Latency, process: proc_start at t+1; done at t+1+k (k>=1); write no earlier than t+k+2.
- Mode is sampled only at capture. Changes mid-sample take effect on the next sample.
- Counters saturate at 2^CNT_W-1 and never wrap.
- writedata_left and writedata_right are driven from one register and are identical in every cycle.
- writedata holds its value outside EMIT.

Decomposition:
- Package audio_seq_pkg holds:
  - state_t enum {IDLE, PROCESS, EMIT}.
  - mode constants MODE_PASS=2'b00, MODE_PROC=2'b01, MODE_MUTE=2'b10.
- Sub-module sat_counter #(CNT_W) provides clk, reset, inc, count. It is instantiated twice, once for timeout_count and once for stall_count.
- The FSM and datapath registers stay in audio_sample_sequencer.

Test Plan:
- Pass mode: mode=00, read_ready=1 at t with readdata_left=24'h12_3456, write_ready=1 -> read=1 at t; write=1 at t+1; writedata_left=writedata_right=24'h123456; busy=0 at t+2.
- Process mode: mode=01, sample 24'h000100; engine asserts proc_done 3 cycles after proc_start with proc_data_out=24'h000080 -> proc_start pulses exactly once with proc_data_in=24'h000100; write carries 24'h000080; timeout_count=0.
- Timeout: TIMEOUT=8, mode=01, proc_done never asserted -> EMIT after 8 PROCESS cycles; writedata=raw sample; timeout_count=1. A second case with proc_done on the 8th cycle -> result used, timeout_count unchanged.
- Mute plus backpressure: mode=10, sample 24'h7FFFFF, write_ready low 5 cycles then high -> writedata=0; write asserted only in the 6th EMIT cycle; stall_count=5; read stays 0 throughout.
- Mode change mid-sample: mode 01 at capture, switched to 10 during PROCESS -> output is the engine result, not 0. The next sample is muted.
- Reset mid-PROCESS: assert reset for 1 cycle 2 cycles after proc_start -> all outputs and counters 0; no write is issued; the next read_ready is accepted normally from IDLE.

Source files
------------

// File: rtl/audio_seq_pkg.sv
// Shared types and constants for the audio sample sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package audio_seq_pkg;

  // START is the first PROCESS cycle, kept as its own state so proc_start decodes cleanly
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    PROCESS = 2'd2,
    EMIT    = 2'd3
  } state_t;

  localparam logic [1:0] MODE_PASS     = 2'b00;
  localparam logic [1:0] MODE_PROC     = 2'b01;
  localparam logic [1:0] MODE_MUTE     = 2'b10;
  localparam logic [1:0] MODE_PROC_ALT = 2'b11;

  // Both 01 and 11 route the sample through the engine
  function automatic logic is_proc_mode(input logic [1:0] m);
    return (m == MODE_PROC) || (m == MODE_PROC_ALT);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for diagnostics.
// Latency: count reflects inc one cycle after the edge that samples it.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Increment on request, stop at the maximum value
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/audio_sample_sequencer.sv
// Moves one codec sample at a time through pass / engine / mute paths to the DAC.
// Latency: pass/mute write at t+1 after read; process writes one cycle after done or timeout.
// Backpressure: read only in IDLE; holds sample in EMIT until write_ready, counting stalls.
module audio_sample_sequencer
  import audio_seq_pkg::*;
#(
  parameter int W       = 24,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             read_ready,
  input  logic             write_ready,
  input  logic [W-1:0]     readdata_left,
  output logic             read,
  output logic             write,
  output logic [W-1:0]     writedata_left,
  output logic [W-1:0]     writedata_right,
  output logic             proc_start,
  output logic [W-1:0]     proc_data_in,
  input  logic             proc_done,
  input  logic [W-1:0]     proc_data_out,
  output logic             busy,
  output logic [CNT_W-1:0] timeout_count,
  output logic [CNT_W-1:0] stall_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic [W-1:0]  sample_q;
  logic [W-1:0]  wdata_q;
  logic [TW-1:0] timer;
  logic          timer_hit;
  logic          timeout_inc;
  logic          stall_inc;

  // timer holds the index (1-based) of the current PROCESS cycle
  assign timer_hit = (timer == TW'(TIMEOUT));

  // Handshakes are state decodes, forced low while reset is asserted
  assign read       = !reset && (state == IDLE) && read_ready;
  assign write      = !reset && (state == EMIT) && write_ready;
  assign proc_start = !reset && (state == START);

  assign proc_data_in    = sample_q;
  assign writedata_left  = wdata_q;
  assign writedata_right = wdata_q;
  assign busy            = (state != IDLE);

  // Done takes priority over timeout, so a late-but-valid result is never counted as a timeout
  assign timeout_inc = (state == PROCESS) && !proc_done && timer_hit;
  assign stall_inc   = (state == EMIT) && !write_ready;

  // Sequencing FSM with the sample and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sample_q <= '0;
      wdata_q  <= '0;
      timer    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (read_ready) begin
            sample_q <= readdata_left;
            timer    <= TW'(1);
            if (is_proc_mode(mode)) begin
              state <= START;
            end else begin
              state   <= EMIT;
              wdata_q <= (mode == MODE_MUTE) ? '0 : readdata_left;
            end
          end
        end
        START: begin
          // done is ignored here: the engine has only just seen proc_start
          timer <= timer + 1'b1;
          state <= PROCESS;
        end
        PROCESS: begin
          if (proc_done) begin
            wdata_q <= proc_data_out;
            state   <= EMIT;
          end else if (timer_hit) begin
            wdata_q <= sample_q;
            state   <= EMIT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        EMIT: begin
          if (write_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_timeout_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (timeout_inc),
    .count (timeout_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_count)
  );

endmodule
